// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-master SRAM arbiter: FSM encoding and the
// byte-to-word address shift.
package sram_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RSP  = 1'b1
    } state_t;

    // Byte address bits dropped to form a 32-bit word index.
    localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester wins; on a tie the master that
// was not granted last wins. Purely combinational.
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two masters share one single-port SRAM with one transaction in flight.
// Read data comes straight from ram_dout, so the RAM address is parked on the last read.
module sram_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int MW = 4
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          m0_cmd_valid,
    output logic          m0_cmd_ready,
    input  logic          m0_cmd_read,
    input  logic [AW-1:0] m0_cmd_addr,
    input  logic [DW-1:0] m0_cmd_wdata,
    input  logic [MW-1:0] m0_cmd_wmask,
    output logic          m0_rsp_valid,
    input  logic          m0_rsp_ready,
    output logic [DW-1:0] m0_rsp_rdata,

    input  logic          m1_cmd_valid,
    output logic          m1_cmd_ready,
    input  logic          m1_cmd_read,
    input  logic [AW-1:0] m1_cmd_addr,
    input  logic [DW-1:0] m1_cmd_wdata,
    input  logic [MW-1:0] m1_cmd_wmask,
    output logic          m1_rsp_valid,
    input  logic          m1_rsp_ready,
    output logic [DW-1:0] m1_rsp_rdata,

    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    output logic          ram_we,
    output logic [MW-1:0] ram_wem,
    input  logic [DW-1:0] ram_dout
);

    import sram_arb_pkg::*;

    logic [1:0]    w_cmd_valid;
    logic [1:0]    w_cmd_read;
    logic [1:0]    w_rsp_ready;
    logic [1:0]    w_grant;
    logic [1:0]    w_cmd_ready;
    logic [1:0]    w_rsp_valid;
    logic [AW-1:0] w_cmd_addr  [2];
    logic [DW-1:0] w_cmd_wdata [2];
    logic [MW-1:0] w_cmd_wmask [2];
    logic [DW-1:0] w_rsp_rdata [2];

    state_t        r_state;
    state_t        w_state_next;
    logic          r_owner;
    logic          r_is_read;
    logic          r_last_grant;
    logic [AW-1:0] r_hold_addr;

    logic          w_rsp_hs;
    logic          w_can_issue;
    logic          w_issue;
    logic          w_sel;
    logic [AW-1:0] w_word_addr;
    logic          w_unused_addr;

    assign w_cmd_valid    = {m1_cmd_valid, m0_cmd_valid};
    assign w_cmd_read     = {m1_cmd_read, m0_cmd_read};
    assign w_rsp_ready    = {m1_rsp_ready, m0_rsp_ready};
    assign w_cmd_addr[0]  = m0_cmd_addr;
    assign w_cmd_addr[1]  = m1_cmd_addr;
    assign w_cmd_wdata[0] = m0_cmd_wdata;
    assign w_cmd_wdata[1] = m1_cmd_wdata;
    assign w_cmd_wmask[0] = m0_cmd_wmask;
    assign w_cmd_wmask[1] = m1_cmd_wmask;
    assign w_unused_addr  = ^{m0_cmd_addr[WORD_OFFSET-1:0], m1_cmd_addr[WORD_OFFSET-1:0]};

    rr_arb2 u_rr_arb2 (
        .i_req        (w_cmd_valid),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    // A new command may issue from IDLE, or from RSP in the cycle the pending response retires.
    assign w_rsp_hs    = (r_state == RSP) && w_rsp_ready[r_owner];
    assign w_can_issue = !rst && ((r_state == IDLE) || w_rsp_hs);
    assign w_issue     = w_can_issue && (|w_grant);
    assign w_sel       = w_grant[1];
    assign w_word_addr = {{WORD_OFFSET{1'b0}}, w_cmd_addr[w_sel][AW-1:WORD_OFFSET]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= 1'b0;
            r_is_read    <= 1'b0;
            r_last_grant <= 1'b1;
            r_hold_addr  <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_issue) begin
                r_owner      <= w_sel;
                r_last_grant <= w_sel;
                r_is_read    <= w_cmd_read[w_sel];
                if (w_cmd_read[w_sel]) begin
                    r_hold_addr <= w_word_addr;
                end
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_issue) w_state_next = RSP;
            RSP:     if (w_rsp_hs && !w_issue) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        ram_addr = r_hold_addr;
        ram_din  = '0;
        ram_we   = 1'b0;
        ram_wem  = '0;
        if (w_issue) begin
            ram_addr = w_word_addr;
            ram_din  = w_cmd_wdata[w_sel];
            ram_we   = !w_cmd_read[w_sel];
            ram_wem  = w_cmd_read[w_sel] ? '0 : w_cmd_wmask[w_sel];
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_master
        assign w_cmd_ready[gi] = w_can_issue && w_grant[gi];
        assign w_rsp_valid[gi] = !rst && (r_state == RSP) && (r_owner == (gi == 1));
        assign w_rsp_rdata[gi] = (w_rsp_valid[gi] && r_is_read) ? ram_dout : '0;
    end

    assign m0_cmd_ready = w_cmd_ready[0];
    assign m1_cmd_ready = w_cmd_ready[1];
    assign m0_rsp_valid = w_rsp_valid[0];
    assign m1_rsp_valid = w_rsp_valid[1];
    assign m0_rsp_rdata = w_rsp_rdata[0];
    assign m1_rsp_rdata = w_rsp_rdata[1];

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a behavioural byte-masked SRAM.
// Inputs change just after the rising edge; outputs are checked on the falling edge.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_cmd_valid = 1'b0, m0_cmd_read = 1'b0, m0_rsp_ready = 1'b0;
    logic [31:0] m0_cmd_addr = '0, m0_cmd_wdata = '0;
    logic [3:0]  m0_cmd_wmask = '0;
    logic        m1_cmd_valid = 1'b0, m1_cmd_read = 1'b0, m1_rsp_ready = 1'b0;
    logic [31:0] m1_cmd_addr = '0, m1_cmd_wdata = '0;
    logic [3:0]  m1_cmd_wmask = '0;
    logic        m0_cmd_ready, m0_rsp_valid, m1_cmd_ready, m1_rsp_valid;
    logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
    logic [31:0] ram_addr, ram_din;
    logic [31:0] ram_dout = '0;
    logic        ram_we;
    logic [3:0]  ram_wem;
    logic [31:0] mem [256];
    wire         unused_hi = ^ram_addr[31:8];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .m0_cmd_valid (m0_cmd_valid),
        .m0_cmd_ready (m0_cmd_ready),
        .m0_cmd_read  (m0_cmd_read),
        .m0_cmd_addr  (m0_cmd_addr),
        .m0_cmd_wdata (m0_cmd_wdata),
        .m0_cmd_wmask (m0_cmd_wmask),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_cmd_valid (m1_cmd_valid),
        .m1_cmd_ready (m1_cmd_ready),
        .m1_cmd_read  (m1_cmd_read),
        .m1_cmd_addr  (m1_cmd_addr),
        .m1_cmd_wdata (m1_cmd_wdata),
        .m1_cmd_wmask (m1_cmd_wmask),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_rdata (m1_rsp_rdata),
        .ram_addr     (ram_addr),
        .ram_din      (ram_din),
        .ram_we       (ram_we),
        .ram_wem      (ram_wem),
        .ram_dout     (ram_dout)
    );

    // SRAM model: masked write when ram_we, otherwise registered read of ram_addr.
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++)
                if (ram_wem[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
        end else begin
            ram_dout <= mem[ram_addr[7:0]];
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int m, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] msk);
        if (m == 0) begin
            m0_cmd_valid = 1'b1; m0_cmd_read = rd; m0_cmd_addr = a;
            m0_cmd_wdata = d; m0_cmd_wmask = msk;
        end else begin
            m1_cmd_valid = 1'b1; m1_cmd_read = rd; m1_cmd_addr = a;
            m1_cmd_wdata = d; m1_cmd_wmask = msk;
        end
    endtask

    task automatic drop(input int m);
        if (m == 0) m0_cmd_valid = 1'b0;
        else        m1_cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cmd(0, 1'b0, 32'h0, 32'h1, 4'hF);
        tick; tick;
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b0 || ram_we !== 1'b0 || ram_wem !== 4'h0) begin
            failures++;
            $display("FAIL reset_outputs: cmd_ready=%b ram_we=%b ram_wem=%h, required 0/0/0",
                     m0_cmd_ready, ram_we, ram_wem);
        end
        checks++;
        if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_rsp_valid: m0=%b m1=%b, required 0/0", m0_rsp_valid, m1_rsp_valid);
        end
        drop(0);
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_addr !== 32'h0 || m0_cmd_ready !== 1'b0 || m0_rsp_rdata !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: ram_addr=%h cmd_ready=%b rdata=%h, required 0/0/0",
                     ram_addr, m0_cmd_ready, m0_rsp_rdata);
        end
        $display("test_reset done");
    endtask

    task automatic test_write_read;
        tick;
        m0_rsp_ready = 1'b0;
        cmd(0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF);
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'h4 ||
            ram_wem !== 4'hF || ram_din !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL wr_issue: ready=%b we=%b addr=%h wem=%h din=%h, required 1/1/4/f/deadbeef",
                     m0_cmd_ready, ram_we, ram_addr, ram_wem, ram_din);
        end
        tick;
        drop(0);
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL wr_rsp: valid=%b rdata=%h we=%b, required 1/0/0",
                     m0_rsp_valid, m0_rsp_rdata, ram_we);
        end
        m0_rsp_ready = 1'b1;
        tick;
        m0_rsp_ready = 1'b0;
        cmd(0, 1'b1, 32'h10, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 32'h4) begin
            failures++;
            $display("FAIL rd_issue: ready=%b we=%b addr=%h, required 1/0/4",
                     m0_cmd_ready, ram_we, ram_addr);
        end
        tick;
        drop(0);
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rd_rsp: valid=%b rdata=%h, required 1/deadbeef", m0_rsp_valid, m0_rsp_rdata);
        end
        m0_rsp_ready = 1'b1;
        tick;
        m0_rsp_ready = 1'b0;
        $display("test_write_read done");
    endtask

    task automatic test_back_to_back;
        cmd(0, 1'b0, 32'h14, 32'h55AA55AA, 4'hF);
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_first_ready: %b, required 1", m0_cmd_ready);
        end
        tick;
        cmd(0, 1'b1, 32'h14, 32'h0, 4'h0);
        m0_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_cmd_ready !== 1'b1 || ram_addr !== 32'h5 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL b2b_issue: rsp_valid=%b ready=%b addr=%h we=%b, required 1/1/5/0",
                     m0_rsp_valid, m0_cmd_ready, ram_addr, ram_we);
        end
        tick;
        drop(0);
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h55AA55AA) begin
            failures++;
            $display("FAIL b2b_rsp: valid=%b rdata=%h, required 1/55aa55aa", m0_rsp_valid, m0_rsp_rdata);
        end
        tick;
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_idle: rsp_valid=%b, required 0", m0_rsp_valid);
        end
        m0_rsp_ready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_round_robin;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        cmd(0, 1'b1, 32'h0, 32'h0, 4'h0);
        cmd(1, 1'b1, 32'h4, 32'h0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (m0_cmd_ready !== (i % 2 == 0) || m1_cmd_ready !== (i % 2 == 1)) begin
                failures++;
                $display("FAIL rr_grant[%0d]: m0=%b m1=%b, required m0=%b m1=%b",
                         i, m0_cmd_ready, m1_cmd_ready, (i % 2 == 0), (i % 2 == 1));
            end
            tick;
            if (i == 7) begin
                drop(0);
                drop(1);
            end
        end
        @(negedge clk);
        checks++;
        if (m1_rsp_valid !== 1'b1 || m0_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rr_last_owner: m0=%b m1=%b, required 0/1", m0_rsp_valid, m1_rsp_valid);
        end
        tick;
        m0_rsp_ready = 1'b0;
        m1_rsp_ready = 1'b0;
        $display("test_round_robin done");
    endtask

    task automatic test_stall;
        cmd(1, 1'b0, 32'h20, 32'hCAFEF00D, 4'hF);
        m1_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m1_cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_preload: ready=%b, required 1", m1_cmd_ready);
        end
        tick;
        drop(1);
        tick;
        m1_rsp_ready = 1'b0;
        cmd(1, 1'b1, 32'h20, 32'h0, 4'h0);
        tick;
        drop(1);
        cmd(0, 1'b0, 32'h30, 32'h12345678, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m1_rsp_valid !== 1'b1 || m1_rsp_rdata !== 32'hCAFEF00D || m0_cmd_ready !== 1'b0 ||
                ram_addr !== 32'h8 || ram_we !== 1'b0 || m0_rsp_rdata !== 32'h0) begin
                failures++;
                $display("FAIL stall[%0d]: valid=%b rdata=%h m0_ready=%b addr=%h we=%b m0_rdata=%h, required 1/cafef00d/0/8/0/0",
                         i, m1_rsp_valid, m1_rsp_rdata, m0_cmd_ready, ram_addr, ram_we, m0_rsp_rdata);
            end
            tick;
        end
        m1_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 32'hC) begin
            failures++;
            $display("FAIL stall_release: m0_ready=%b we=%b addr=%h, required 1/1/c",
                     m0_cmd_ready, ram_we, ram_addr);
        end
        tick;
        drop(0);
        m1_rsp_ready = 1'b0;
        m0_rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h0 || m1_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL stall_m0_rsp: valid=%b rdata=%h m1_valid=%b, required 1/0/0",
                     m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid);
        end
        tick;
        m0_rsp_ready = 1'b0;
        $display("test_stall done");
    endtask

    task automatic test_byte_mask;
        m0_rsp_ready = 1'b1;
        cmd(0, 1'b0, 32'h40, 32'h11223344, 4'hF);
        tick;
        cmd(0, 1'b0, 32'h40, 32'h0000AB00, 4'b0010);
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b1 || ram_wem !== 4'b0010 || ram_din !== 32'h0000AB00 || ram_addr !== 32'h10) begin
            failures++;
            $display("FAIL mask_issue: ready=%b wem=%h din=%h addr=%h, required 1/2/0000ab00/10",
                     m0_cmd_ready, ram_wem, ram_din, ram_addr);
        end
        tick;
        cmd(0, 1'b1, 32'h40, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (ram_wem !== 4'h0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL mask_read_wem: wem=%h we=%b, required 0/0", ram_wem, ram_we);
        end
        tick;
        drop(0);
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'h1122AB44) begin
            failures++;
            $display("FAIL mask_readback: valid=%b rdata=%h, required 1/1122ab44", m0_rsp_valid, m0_rsp_rdata);
        end
        tick;
        m0_rsp_ready = 1'b0;
        $display("test_byte_mask done");
    endtask

    task automatic test_reset_in_rsp;
        cmd(0, 1'b1, 32'h10, 32'h0, 4'h0);
        tick;
        drop(0);
        rst = 1'b1;
        m0_rsp_ready = 1'b1;
        cmd(0, 1'b1, 32'h10, 32'h0, 4'h0);
        cmd(1, 1'b1, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        checks++;
        if (m0_cmd_ready !== 1'b0 || m1_cmd_ready !== 1'b0 || ram_we !== 1'b0) begin
            failures++;
            $display("FAIL rst_rsp_priority: m0_ready=%b m1_ready=%b we=%b, required 0/0/0",
                     m0_cmd_ready, m1_cmd_ready, ram_we);
        end
        tick;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b0 || m1_rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_rsp_dropped: m0=%b m1=%b, required 0/0", m0_rsp_valid, m1_rsp_valid);
        end
        checks++;
        if (m0_cmd_ready !== 1'b1 || m1_cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_rsp_tie: m0=%b m1=%b, required 1/0", m0_cmd_ready, m1_cmd_ready);
        end
        tick;
        drop(0);
        drop(1);
        @(negedge clk);
        checks++;
        if (m0_rsp_valid !== 1'b1 || m0_rsp_rdata !== 32'hDEADBEEF) begin
            failures++;
            $display("FAIL rst_rsp_after: valid=%b rdata=%h, required 1/deadbeef", m0_rsp_valid, m0_rsp_rdata);
        end
        tick;
        m0_rsp_ready = 1'b0;
        $display("test_reset_in_rsp done");
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write_read;
        test_back_to_back;
        test_round_robin;
        test_stall;
        test_byte_mask;
        test_reset_in_rsp;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width of master and RAM ports.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter MW, default 4, meaning byte write-mask width (DW/8).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have, for N in {0,1}: mN_cmd_valid  input  1  command request.
REQ-007 SHALL have mN_cmd_ready  output  1  command accepted when high together with mN_cmd_valid.
REQ-008 SHALL have mN_cmd_read  input  1  1 = read, 0 = write.
REQ-009 SHALL have mN_cmd_addr  input  AW  byte address.
REQ-010 SHALL have mN_cmd_wdata  input  DW  write data.
REQ-011 SHALL have mN_cmd_wmask  input  MW  byte enables for writes.
REQ-012 SHALL have mN_rsp_valid  output  1  response available.
REQ-013 SHALL have mN_rsp_ready  input  1  response consumed when high together with mN_rsp_valid.
REQ-014 SHALL have mN_rsp_rdata  output  DW  read data; 0 for write responses.
REQ-015 SHALL have ram_addr  output  AW  RAM word index.
REQ-016 SHALL have ram_din  output  DW  RAM write data.
REQ-017 SHALL have ram_we  output  1  RAM write enable; RAM latches a read address whenever ram_we is low.
REQ-018 SHALL have ram_wem  output  MW  RAM byte write mask.
REQ-019 SHALL have ram_dout  input  DW  RAM read data, valid one cycle after the read address is presented and held while that address is re-presented.

Function
REQ-020 SHALL use states IDLE and RSP, with exactly one transaction outstanding at a time.
REQ-021 SHALL assert mN_cmd_ready only for the granted master, and only in IDLE or in RSP during the cycle the pending response handshakes (back-to-back issue).
REQ-022 SHALL grant round-robin: a single valid master wins; when both are valid, the master not granted last wins; last_grant updates on every command handshake.
REQ-023 SHALL, on a command handshake, drive ram_addr = {2'b00, cmd_addr[AW-1:2]} combinationally in the same cycle, with ram_we = ~cmd_read, ram_wem = cmd_read ? 0 : cmd_wmask, ram_din = cmd_wdata.
REQ-024 SHALL record the owner master and transaction type on a command handshake, and go to RSP.
REQ-025 SHALL, when not issuing a command, drive ram_we = 0, ram_wem = 0, and ram_addr = hold_addr (the last read word index issued), so that the RAM output is never disturbed.
REQ-026 SHALL update hold_addr only on read handshakes; write handshakes leave hold_addr and ram_dout unchanged.
REQ-027 SHALL, in RSP, assert rsp_valid to the owner only; for reads, rsp_rdata = ram_dout (latency 1 cycle from command handshake to first rsp_valid); for writes, rsp_rdata = 0.
REQ-028 SHALL hold rsp_valid and rsp_rdata stable while rsp_ready is low, for any number of stall cycles.
REQ-029 SHALL, on a response handshake with no new command, return to IDLE; with a new command in the same cycle, stay in RSP with the new owner.
REQ-030 SHALL drive mN_rsp_rdata = 0 whenever mN_rsp_valid is low.

Reset
REQ-031 SHALL, on rst, set state = IDLE, owner = 0, last_grant = 1 (m0 wins first tie), hold_addr = 0; all cmd_ready/rsp_valid/ram_we/ram_wem = 0.
REQ-032 SHALL, on rst asserted in RSP, drop the pending response with no rsp_valid in the following cycle; rst has priority over any simultaneous handshake.

Structure
REQ-033 SHALL place the state encoding (IDLE, RSP) and the word-offset constant (2) in package sram_arb_pkg.
REQ-034 SHALL implement grant selection in sub-module rr_arb2 (2 requests, last_grant input, one-hot grant output, combinational).

Verification
REQ-035 SHALL cover: m0 write addr 0x10 data 0xDEADBEEF mask 4'hF, then m0 read 0x10 -> rsp_rdata 0xDEADBEEF one cycle after the read handshake.
REQ-036 SHALL cover: m0 and m1 valid simultaneously for 4 commands each, starting after reset -> grant order m0,m1,m0,m1,...
REQ-037 SHALL cover: m1 read 0x20 with rsp_ready low for 5 cycles while m0 holds a pending write -> rsp_rdata stable for all 5 cycles, no m0 cmd_ready, ram_addr = 0x8 throughout.
REQ-038 SHALL cover: byte write mask 4'b0010 data 0x0000AB00 over 0x11223344 -> readback 0x1122AB44.
REQ-039 SHALL cover: rsp_ready high with a new m0 command in the same cycle -> next command issued with no IDLE bubble.
REQ-040 SHALL cover: rst asserted in RSP -> rsp_valid low next cycle, state IDLE, m0 wins the next tie.
